// File: rtl/pio_osr.sv
// PIO output shift register for one state machine: OUT / PULL / MOV-to-OSR
// with TX FIFO autopull, advanced only on divider-enabled cycles.
module pio_osr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             cfg_shift_right,
    input  logic             cfg_autopull,
    input  logic [4:0]       cfg_pull_thresh,
    input  logic             out_req,
    input  logic [4:0]       out_count,
    input  logic             pull_req,
    input  logic             pull_block,
    input  logic             mov_load,
    input  logic [WIDTH-1:0] mov_data,
    input  logic [WIDTH-1:0] x_data,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_valid,
    output logic             fifo_pop,
    output logic             stall,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [5:0]       osr_count,
    output logic [WIDTH-1:0] osr_value
);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_MOV,
        OP_PULL,
        OP_OUT
    } op_e;

    logic [WIDTH-1:0] osr_q, osr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             pop_c, stall_c;
    op_e              op;
    logic [5:0]       thr, n;
    logic             refill_due;
    logic [WIDTH-1:0] mask, shr_data, shr_osr, shl_data, shl_osr;
    logic [6:0]       cnt_sum;
    logic [5:0]       cnt_sat;

    // 5-bit fields encode 32 as 0
    assign thr = (cfg_pull_thresh == 5'd0) ? 6'd32 : {1'b0, cfg_pull_thresh};
    assign n   = (out_count == 5'd0)       ? 6'd32 : {1'b0, out_count};

    assign refill_due = cfg_autopull && (cnt_q >= thr);

    always_comb begin
        op = OP_NONE;
        if (mov_load)      op = OP_MOV;
        else if (pull_req) op = OP_PULL;
        else if (out_req)  op = OP_OUT;
    end

    // Full-width shifts are special-cased so no shift amount ever reaches WIDTH
    always_comb begin
        mask     = '1;
        shr_data = osr_q;
        shr_osr  = '0;
        shl_data = osr_q;
        shl_osr  = '0;
        if (n != 6'd32) begin
            mask     = (WIDTH'(1) << n) - WIDTH'(1);
            shr_data = osr_q & mask;
            shr_osr  = osr_q >> n;
            shl_data = osr_q >> (6'd32 - n);
            shl_osr  = osr_q << n;
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + {1'b0, n};
    assign cnt_sat = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

    always_comb begin
        osr_d       = osr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        pop_c       = 1'b0;
        stall_c     = 1'b0;
        if (penable) begin
            case (op)
                OP_MOV: begin
                    osr_d = mov_data;
                    cnt_d = 6'd0;
                end
                OP_PULL: begin
                    if (cfg_autopull && (cnt_q < thr)) begin
                        // OSR still holds enough data: PULL is a no-op
                    end else if (fifo_valid) begin
                        osr_d = fifo_data;
                        cnt_d = 6'd0;
                        pop_c = 1'b1;
                    end else if (pull_block) begin
                        stall_c = 1'b1;
                    end else begin
                        osr_d = x_data;
                        cnt_d = 6'd0;
                    end
                end
                OP_OUT: begin
                    if (refill_due) begin
                        // Refill first; the OUT itself retries next enabled cycle
                        stall_c = 1'b1;
                        if (fifo_valid) begin
                            osr_d = fifo_data;
                            cnt_d = 6'd0;
                            pop_c = 1'b1;
                        end
                    end else begin
                        osr_d       = cfg_shift_right ? shr_osr : shl_osr;
                        out_data_d  = cfg_shift_right ? shr_data : shl_data;
                        cnt_d       = cnt_sat;
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    if (refill_due && fifo_valid) begin
                        osr_d = fifo_data;
                        cnt_d = 6'd0;
                        pop_c = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            osr_q       <= '0;
            cnt_q       <= 6'd32;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            osr_q       <= osr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshakes drop as soon as reset asserts, even mid-stall
    assign fifo_pop  = pop_c & reset;
    assign stall     = stall_c & reset;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign osr_count = cnt_q;
    assign osr_value = osr_q;

endmodule

// File: tb/tb_pio_osr.sv
// Bench for pio_osr: directed scenarios plus random traffic, all checked
// against an arithmetic reference model and a queue-based TX FIFO.
module tb_pio_osr;
    logic        clk = 1'b0;
    logic        reset;
    logic        penable, cfg_shift_right, cfg_autopull;
    logic [4:0]  cfg_pull_thresh, out_count;
    logic        out_req, pull_req, pull_block, mov_load;
    logic [31:0] mov_data, x_data, fifo_data;
    logic        fifo_valid;
    logic        fifo_pop, stall, out_valid;
    logic [31:0] out_data, osr_value;
    logic [5:0]  osr_count;

    always #5 clk = ~clk;

    pio_osr #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .penable(penable),
        .cfg_shift_right(cfg_shift_right), .cfg_autopull(cfg_autopull),
        .cfg_pull_thresh(cfg_pull_thresh), .out_req(out_req), .out_count(out_count),
        .pull_req(pull_req), .pull_block(pull_block), .mov_load(mov_load),
        .mov_data(mov_data), .x_data(x_data), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_pop(fifo_pop), .stall(stall),
        .out_data(out_data), .out_valid(out_valid), .osr_count(osr_count),
        .osr_value(osr_value)
    );

    int checks = 0;
    int errors = 0;

    bit [31:0] m_osr, m_out;
    int        m_cnt;
    bit        m_vld;
    bit [31:0] fq[$];
    logic      obs_stall, obs_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_osr = 32'd0;
        m_cnt = 32;
        m_out = 32'd0;
        m_vld = 1'b0;
    endtask

    // One clock: predict, check the combinational handshakes, clock, check state.
    task automatic cyc(input string tag);
        bit              e_stall, e_pop, nvld, pend;
        bit [31:0]       nosr, nout;
        int              ncnt, thr, n;
        longint unsigned p, prod;
        fifo_valid = (fq.size() != 0);
        fifo_data  = fifo_valid ? fq[0] : $urandom;
        #1;
        thr = (cfg_pull_thresh == 0) ? 32 : int'(cfg_pull_thresh);
        n   = (out_count == 0) ? 32 : int'(out_count);
        pend = cfg_autopull && (m_cnt >= thr);
        e_stall = 0; e_pop = 0; nvld = 0;
        nosr = m_osr; ncnt = m_cnt; nout = m_out;
        if (penable) begin
            if (mov_load) begin
                nosr = mov_data; ncnt = 0;
            end else if (pull_req) begin
                if (cfg_autopull && m_cnt < thr) begin
                end else if (fifo_valid) begin
                    nosr = fifo_data; ncnt = 0; e_pop = 1;
                end else if (pull_block) begin
                    e_stall = 1;
                end else begin
                    nosr = x_data; ncnt = 0;
                end
            end else if (out_req) begin
                if (pend) begin
                    e_stall = 1;
                    if (fifo_valid) begin
                        nosr = fifo_data; ncnt = 0; e_pop = 1;
                    end
                end else begin
                    p = 64'd1 << n;
                    if (cfg_shift_right) begin
                        nout = 32'(longint'(m_osr) % p);
                        nosr = 32'(longint'(m_osr) / p);
                    end else begin
                        prod = longint'(m_osr) * p;
                        nout = prod[63:32];
                        nosr = prod[31:0];
                    end
                    ncnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
                    nvld = 1;
                end
            end else if (pend && fifo_valid) begin
                nosr = fifo_data; ncnt = 0; e_pop = 1;
            end
        end
        obs_stall = stall;
        obs_pop   = fifo_pop;
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".pop"}, 32'(fifo_pop), 32'(e_pop));
        @(posedge clk);
        #1;
        m_osr = nosr; m_cnt = ncnt; m_out = nout; m_vld = nvld;
        if (e_pop) void'(fq.pop_front());
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_data"}, out_data, m_out);
        chk({tag, ".osr_count"}, 32'(osr_count), 32'(m_cnt));
        chk({tag, ".osr_value"}, osr_value, m_osr);
    endtask

    task automatic idle();
        penable = 1; out_req = 0; pull_req = 0; pull_block = 0; mov_load = 0;
    endtask

    task automatic load(input bit [31:0] v);
        idle();
        mov_load = 1; mov_data = v;
        cyc("mov");
        mov_load = 0;
    endtask

    initial begin
        int pulses;
        reset = 0;
        idle();
        cfg_shift_right = 1; cfg_autopull = 0; cfg_pull_thresh = 0; out_count = 0;
        mov_data = 0; x_data = 0; fifo_data = 0; fifo_valid = 0;
        pull_req = 1; pull_block = 1;
        #12;
        model_reset();
        chk("rst.osr_count", 32'(osr_count), 32'd32);
        chk("rst.osr_value", osr_value, 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.fifo_pop", 32'(fifo_pop), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        @(negedge clk) reset = 1;
        idle();
        @(posedge clk); #1;
        cyc("idle");

        // OUT 8 shift right
        load(32'hDEADBEEF);
        out_req = 1; out_count = 8;
        cyc("outr8");
        chk("outr8.data", out_data, 32'hEF);
        chk("outr8.osr", osr_value, 32'h00DEADBE);
        chk("outr8.cnt", 32'(osr_count), 32'd8);

        // OUT 8 shift left
        cfg_shift_right = 0;
        load(32'hDEADBEEF);
        out_req = 1; out_count = 8;
        cyc("outl8");
        chk("outl8.data", out_data, 32'hDE);
        chk("outl8.osr", osr_value, 32'hADBEEF00);

        // Full-width OUTs saturate the count
        cfg_shift_right = 1;
        load(32'hDEADBEEF);
        out_req = 1; out_count = 0;
        cyc("out32a");
        chk("out32.data", out_data, 32'hDEADBEEF);
        chk("out32.osr", osr_value, 32'd0);
        chk("out32.cnt", 32'(osr_count), 32'd32);
        for (int i = 0; i < 3; i++) cyc("out32b");
        chk("out32.sat", 32'(osr_count), 32'd32);

        // Autopull stalls the OUT, refills, then the OUT completes
        cfg_autopull = 1; cfg_pull_thresh = 16;
        load(32'hFFFF0000);
        out_req = 1; out_count = 16;
        cyc("ap_fill");
        chk("ap.cnt16", 32'(osr_count), 32'd16);
        fq.push_back(32'h12345678);
        out_count = 4;
        cyc("ap_refill");
        chk("ap.stall", 32'(obs_stall), 32'd1);
        chk("ap.pop", 32'(obs_pop), 32'd1);
        cyc("ap_out");
        chk("ap.data", out_data, 32'h8);
        chk("ap.cnt4", 32'(osr_count), 32'd4);

        // Blocking PULL on empty FIFO
        cfg_autopull = 0;
        idle();
        pull_req = 1; pull_block = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("pullblk");
            chk("pullblk.stall", 32'(obs_stall), 32'd1);
            chk("pullblk.nopop", 32'(obs_pop), 32'd0);
        end
        fq.push_back(32'hCAFEF00D);
        cyc("pullgo");
        chk("pullgo.pop", 32'(obs_pop), 32'd1);
        chk("pullgo.stall", 32'(obs_stall), 32'd0);
        chk("pullgo.cnt", 32'(osr_count), 32'd0);
        chk("pullgo.osr", osr_value, 32'hCAFEF00D);

        // Non-blocking PULL falls back to X
        pull_block = 0; x_data = 32'hA5A5A5A5;
        cyc("pullx");
        chk("pullx.osr", osr_value, 32'hA5A5A5A5);

        // Divider enable 1-of-3 with OUT held
        load(32'h87654321);
        out_req = 1; out_count = 4;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            penable = (i % 3 == 0);
            cyc("pen");
            if (out_valid === 1'b1) pulses++;
        end
        chk("pen.pulses", 32'(pulses), 32'd3);
        chk("pen.osr", osr_value, 32'h00087654);

        // Reset while stalled
        idle();
        pull_req = 1; pull_block = 1;
        fifo_valid = 0;
        #1;
        chk("rststall.pre", 32'(stall), 32'd1);
        reset = 0;
        #1;
        model_reset();
        chk("rststall.stall", 32'(stall), 32'd0);
        chk("rststall.cnt", 32'(osr_count), 32'd32);
        chk("rststall.osr", osr_value, 32'd0);
        @(negedge clk) reset = 1;
        idle();
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            penable         = ($urandom_range(0, 3) != 0);
            mov_load        = ($urandom_range(0, 9) == 0);
            pull_req        = ($urandom_range(0, 5) == 0);
            pull_block      = $urandom_range(0, 1);
            out_req         = $urandom_range(0, 1);
            out_count       = 5'($urandom);
            mov_data        = $urandom;
            x_data          = $urandom;
            cfg_shift_right = $urandom_range(0, 1);
            if (i % 50 == 0) begin
                cfg_autopull    = $urandom_range(0, 1);
                cfg_pull_thresh = 5'($urandom);
            end
            if ($urandom_range(0, 2) == 0 && fq.size() < 4) fq.push_back($urandom);
            cyc("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_osr.md
Name: pio_osr

Overview:
- PIO output shift register (OSR) stage, downstream of the clock divider.
- Advances only on cycles where the divider's `penable` is high.
- Executes OUT, PULL and MOV-to-OSR operations for one state machine, with autopull from the TX FIFO.
- Returns shifted data to the pin/scratch mux and a stall flag to the instruction sequencer.

Parameters:
- WIDTH, 32: OSR and FIFO word width. Only 32 is supported; the count widths below assume it.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- penable  input  1  execution enable from the divider; all state changes are gated by it
- cfg_shift_right  input  1  1 = shift out of the LSB end, 0 = out of the MSB end
- cfg_autopull  input  1  autopull enable
- cfg_pull_thresh  input  5  autopull threshold in bits; 0 encodes 32
- out_req  input  1  OUT instruction executing this cycle
- out_count  input  5  bit count for OUT; 0 encodes 32
- pull_req  input  1  PULL instruction executing
- pull_block  input  1  PULL is blocking
- mov_load  input  1  MOV OSR, src
- mov_data  input  32  MOV source value
- x_data  input  32  scratch X, loaded by a non-blocking PULL when the FIFO is empty
- fifo_data  input  32  TX FIFO head
- fifo_valid  input  1  TX FIFO not empty
- fifo_pop  output  1  pop TX FIFO head; combinational
- stall  output  1  instruction cannot complete; sequencer holds PC; combinational
- out_data  output  32  shifted-out bits, right-justified, zero-filled; registered
- out_valid  output  1  out_data valid; registered one-clk pulse
- osr_count  output  6  shift count, 0 = full, 32 = empty
- osr_value  output  32  current OSR contents

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (asynchronous, reset low): osr_value=0, osr_count=32, out_data=0, out_valid=0. fifo_pop=0 and stall=0 while reset is asserted.
- penable low:
  - all registers hold; requests are ignored
  - fifo_pop=0, stall=0
  - out_valid is cleared on the next clk
- Request priority: mov_load > pull_req > out_req. Lower-priority requests in the same cycle are ignored.
- Threshold: `thr` = cfg_pull_thresh, or 32 if that field is 0. `n` = out_count, or 32 if that field is 0.
- MOV (penable=1):
  - osr_value ← mov_data; osr_count ← 0
  - stall=0, no pop
- PULL (penable=1):
  - cfg_autopull=1 and osr_count < thr: no-op, stall=0.
  - else if fifo_valid: osr_value ← fifo_data, osr_count ← 0, fifo_pop=1, stall=0.
  - else if pull_block: stall=1, state unchanged.
  - else: osr_value ← x_data, osr_count ← 0, stall=0.
- OUT (penable=1):
  - Autopull pending (cfg_autopull=1 and osr_count ≥ thr):
    - fifo_valid=1: osr_value ← fifo_data, osr_count ← 0, fifo_pop=1, stall=1. The OUT retries on the next enabled cycle.
    - fifo_valid=0: stall=1, no state change.
  - Otherwise:
    - shift right: out_data ← osr[n-1:0], osr ← osr >> n
    - shift left: out_data ← osr[31:32-n] right-justified, osr ← osr << n
    - n=32: out_data ← osr, osr ← 0
    - osr_count ← min(osr_count + n, 32), saturating with no wrap
    - out_valid ← 1 on the next clk; stall=0
- Background autopull (penable=1, no request, cfg_autopull=1, osr_count ≥ thr, fifo_valid): refill as above with fifo_pop=1.
- Pop guarantee: fifo_pop is never asserted while fifo_valid=0. At most one pop per enabled cycle.
- Reset mid-stall: all state clears; the stall drops immediately.

Test Plan:
- Reset release → osr_count=32, osr_value=0, out_valid=0, fifo_pop=0.
- MOV 0xDEADBEEF, then OUT n=8 with shift right → out_data=0xEF, osr_value=0x00DEADBE, osr_count=8.
- Same load, OUT n=8 with shift left → out_data=0xDE, osr_value=0xADBEEF00.
- Four OUT n=0 (32 bits) with osr_count=0 → first gives out_data=0xDEADBEEF, osr=0, osr_count=32; later OUTs keep osr_count=32 (saturates).
- Autopull thr=16, osr_count=16, FIFO holds 0x12345678; OUT n=4 with shift right:
  - cycle 1: stall=1, fifo_pop=1
  - next enabled cycle: out_data=0x8, osr_count=4
- Blocking PULL with FIFO empty → stall held high and no pop for 5 enabled cycles; FIFO fills → pop, stall=0, osr_count=0.
- Non-blocking PULL, FIFO empty, x_data=0xA5A5A5A5 → osr_value=0xA5A5A5A5.
- penable toggling 1-of-3 with out_req held → shifts only on enabled cycles, and out_valid pulses once per enabled cycle.
